// File: rtl/serial_mem_ctrl_if.sv
// Request/grant handshakes for the CPU and DMA ports plus the bit-serial
// core-memory bus. The slave side is the controller. The master side is the
// environment: the requesters and the memory array.
interface serial_mem_ctrl_if #(
    parameter int AW  = 7,
    parameter int WW  = 12,
    parameter int BAW = 4
) ();
    logic           cpu_req;
    logic           cpu_we;
    logic [AW-1:0]  cpu_addr;
    logic [WW-1:0]  cpu_wdata;
    logic           cpu_gnt;
    logic           cpu_done;

    logic           dma_req;
    logic           dma_we;
    logic [AW-1:0]  dma_addr;
    logic [WW-1:0]  dma_wdata;
    logic           dma_gnt;
    logic           dma_done;

    logic [WW-1:0]  rdata;
    logic           busy;

    logic [AW-1:0]  ma;
    logic [BAW-1:0] ba;
    logic           mb;
    logic           write;
    logic           membus;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_done,
        output rdata, busy,
        output ma, ba, mb, write,
        input  membus
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_done,
        input  rdata, busy,
        input  ma, ba, mb, write,
        output membus
    );
endinterface

// File: rtl/serial_mem_ctrl.sv
// Word-level controller for a bit-serial core memory. Two requesters are
// arbitrated round-robin. Each whole-word access is serialised LSB-first over
// ma/ba/mb/write. Read bits are reassembled into a full word. Completion is
// reported with a one-cycle done pulse to the port that owns the memory.
module serial_mem_ctrl #(
    parameter int AW  = 7,
    parameter int WW  = 12,
    parameter int BAW = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    serial_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WSET, WPUL, WHOLD, DONE} state_t;

    localparam logic [BAW-1:0] LAST_BIT = BAW'(WW - 1);

    state_t         state_reg;
    logic           owner_reg;      // 1 = DMA owns the current access
    logic           last_dma_reg;   // 1 = DMA was served last; CPU wins the next tie
    logic [WW-1:0]  wdata_reg;
    logic [WW-1:0]  shadow_reg;
    logic [WW-1:0]  rdata_reg;
    logic [AW-1:0]  ma_reg;
    logic [BAW-1:0] ba_reg;
    logic           mb_reg;
    logic           write_reg;
    logic           cpu_gnt_reg;
    logic           dma_gnt_reg;
    logic           cpu_done_reg;
    logic           dma_done_reg;
    logic           busy_reg;

    logic           pick_dma;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [WW-1:0]  sel_wdata;
    logic [BAW-1:0] ba_inc;
    logic [WW-1:0]  shadow_next;

    // Arbitration winner and its latched-at-grant request fields.
    always_comb begin
        pick_dma  = bus.dma_req & (~bus.cpu_req | ~last_dma_reg);
        sel_we    = pick_dma ? bus.dma_we    : bus.cpu_we;
        sel_addr  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
        sel_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
        ba_inc    = ba_reg + 1'b1;
    end

    // Read shadow with the bit at the current bit address replaced by membus.
    // The full word is copied to rdata only once all bits are in, so rdata
    // never shows a partial word.
    genvar gi;
    generate
        for (gi = 0; gi < WW; gi++) begin : g_shadow
            assign shadow_next[gi] = (ba_reg == BAW'(gi)) ? bus.membus : shadow_reg[gi];
        end
    endgenerate

    // Access sequencer. It produces all registered outputs. A reset drops
    // write on the very next edge, so a word write in flight is left partial.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            last_dma_reg <= 1'b1;
            wdata_reg    <= '0;
            shadow_reg   <= '0;
            rdata_reg    <= '0;
            ma_reg       <= '0;
            ba_reg       <= '0;
            mb_reg       <= 1'b0;
            write_reg    <= 1'b0;
            cpu_gnt_reg  <= 1'b0;
            dma_gnt_reg  <= 1'b0;
            cpu_done_reg <= 1'b0;
            dma_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            cpu_done_reg <= 1'b0;
            dma_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        owner_reg    <= pick_dma;
                        last_dma_reg <= pick_dma;
                        cpu_gnt_reg  <= ~pick_dma;
                        dma_gnt_reg  <= pick_dma;
                        ma_reg       <= sel_addr;
                        ba_reg       <= '0;
                        wdata_reg    <= sel_wdata;
                        busy_reg     <= 1'b1;
                        if (sel_we) begin
                            mb_reg    <= sel_wdata[0];
                            state_reg <= WSET;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    shadow_reg <= shadow_next;
                    if (ba_reg == LAST_BIT) begin
                        rdata_reg    <= shadow_next;
                        cpu_done_reg <= ~owner_reg;
                        dma_done_reg <= owner_reg;
                        state_reg    <= DONE;
                    end else begin
                        ba_reg <= ba_inc;
                    end
                end
                WSET: begin
                    write_reg <= 1'b1;
                    state_reg <= WPUL;
                end
                WPUL: begin
                    write_reg <= 1'b0;
                    state_reg <= WHOLD;
                end
                WHOLD: begin
                    if (ba_reg == LAST_BIT) begin
                        cpu_done_reg <= ~owner_reg;
                        dma_done_reg <= owner_reg;
                        state_reg    <= DONE;
                    end else begin
                        ba_reg    <= ba_inc;
                        mb_reg    <= wdata_reg[ba_inc];
                        state_reg <= WSET;
                    end
                end
                DONE: begin
                    cpu_gnt_reg <= 1'b0;
                    dma_gnt_reg <= 1'b0;
                    ba_reg      <= '0;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_gnt  = cpu_gnt_reg;
    assign bus.dma_gnt  = dma_gnt_reg;
    assign bus.cpu_done = cpu_done_reg;
    assign bus.dma_done = dma_done_reg;
    assign bus.rdata    = rdata_reg;
    assign bus.busy     = busy_reg;
    assign bus.ma       = ma_reg;
    assign bus.ba       = ba_reg;
    assign bus.mb       = mb_reg;
    assign bus.write    = write_reg;
endmodule

// File: tb/tb_serial_mem_ctrl.sv
// Bench for serial_mem_ctrl. It provides a bit-serial core memory, two
// queue-fed requesters and a word-level reference model. The model covers
// round-robin choice, latency, word contents and bus stability.
module tb_serial_mem_ctrl;
    localparam int AW  = 7;
    localparam int WW  = 12;
    localparam int BAW = 4;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    serial_mem_ctrl_if #(.AW(AW), .WW(WW), .BAW(BAW)) bus ();

    serial_mem_ctrl #(.AW(AW), .WW(WW), .BAW(BAW)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    // Core memory: combinational read bit, commit on falling edge of write.
    logic [WW-1:0] mem     [0:(1<<AW)-1];
    logic [WW-1:0] exp_mem [0:(1<<AW)-1];
    int            wr_falls = 0;

    assign bus.membus = mem[bus.ma][bus.ba];

    always @(negedge bus.write) begin
        if (!reset) begin
            mem[bus.ma][bus.ba] = bus.mb;
            wr_falls++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        int            gap;
        logic          drop;
    } req_t;

    req_t cpu_q[$];
    req_t dma_q[$];
    logic active [2];
    int   grant_log[$];

    task automatic set_port(input int p, input logic req, input req_t r);
        if (p == 0) begin
            bus.cpu_req = req; bus.cpu_we = r.we; bus.cpu_addr = r.addr; bus.cpu_wdata = r.wdata;
        end else begin
            bus.dma_req = req; bus.dma_we = r.we; bus.dma_addr = r.addr; bus.dma_wdata = r.wdata;
        end
    endtask

    function automatic logic done_of(input int p);
        return (p == 0) ? bus.cpu_done : bus.dma_done;
    endfunction

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.cpu_gnt : bus.dma_gnt;
    endfunction

    // One requester: pops a request, holds req until done (or reset), may drop req early.
    task automatic drive_port(input int p);
        req_t r;
        bit   got;
        bit   dropped;
        int   waited;
        r = '{we: 1'b0, addr: '0, wdata: '0, gap: 0, drop: 1'b0};
        set_port(p, 1'b0, r);
        active[p] = 1'b0;
        forever begin
            @(negedge sysclk); #1;
            got = 0;
            if (p == 0 && cpu_q.size() > 0) begin r = cpu_q.pop_front(); got = 1; end
            if (p == 1 && dma_q.size() > 0) begin r = dma_q.pop_front(); got = 1; end
            if (got) begin
                active[p] = 1'b1;
                if (r.gap > 0) begin
                    repeat (r.gap) @(negedge sysclk);
                    #1;
                end
                set_port(p, 1'b1, r);
                dropped = 0;
                waited  = 0;
                while (1) begin
                    @(negedge sysclk); #1;
                    if (reset || done_of(p)) break;
                    if (r.drop && !dropped && gnt_of(p)) begin
                        set_port(p, 1'b0, r);
                        dropped = 1;
                    end
                    waited++;
                    if (waited > 300) begin
                        check($sformatf("timeout_port%0d", p), 0, 1);
                        break;
                    end
                end
                set_port(p, 1'b0, r);
                active[p] = 1'b0;
            end
        end
    endtask

    initial drive_port(0);
    initial drive_port(1);

    // Reference model state, sampled 1 time unit after each rising edge.
    logic          prev_write = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_mb = 1'b0;
    logic [AW-1:0] prev_ma  = '0;
    logic [BAW-1:0] prev_ba = '0;
    logic          gnt_any, done_any, exp_grant;
    int            win, owner, cyc, falls0;
    int            last_dma  = 1;
    int            in_access = 0;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [WW-1:0] cur_wdata;
    logic [WW-1:0] exp_rdata = '0;

    initial begin : monitor
        forever begin
            @(posedge sysclk); #1;
            gnt_any  = bus.cpu_gnt | bus.dma_gnt;
            done_any = bus.cpu_done | bus.dma_done;
            if (reset) begin
                in_access = 0;
                last_dma  = 1;
                exp_rdata = '0;
                done_any  = 1'b0;
            end else begin
                check("two_gnt", 32'(bus.cpu_gnt & bus.dma_gnt), 0);
                check("two_done", 32'(bus.cpu_done & bus.dma_done), 0);
                if (bus.write || prev_write)
                    check("bus_stable", 32'({bus.ma, bus.ba, bus.mb}), 32'({prev_ma, prev_ba, prev_mb}));
                if (prev_done) begin
                    check("gnt_after_done", 32'(gnt_any), 0);
                    check("busy_after_done", 32'(bus.busy), 0);
                    check("done_width", 32'(done_any), 0);
                end
                if (!prev_busy) begin
                    exp_grant = bus.cpu_req | bus.dma_req;
                    check("idle_grant", 32'(gnt_any), 32'(exp_grant));
                    if (exp_grant) begin
                        if (bus.cpu_req && bus.dma_req) win = (last_dma != 0) ? 0 : 1;
                        else                            win = bus.dma_req ? 1 : 0;
                        check("winner", 32'(bus.dma_gnt), win);
                        check("busy_at_grant", 32'(bus.busy), 1);
                        last_dma  = win;
                        owner     = win;
                        cur_we    = (win == 1) ? bus.dma_we    : bus.cpu_we;
                        cur_addr  = (win == 1) ? bus.dma_addr  : bus.cpu_addr;
                        cur_wdata = (win == 1) ? bus.dma_wdata : bus.cpu_wdata;
                        cyc       = 1;
                        falls0    = wr_falls;
                        in_access = 1;
                        grant_log.push_back(win);
                    end
                end else if (in_access != 0) begin
                    cyc++;
                end
                if (in_access != 0) begin
                    check("ma_hold", 32'(bus.ma), 32'(cur_addr));
                    if (!cur_we && cyc <= WW)     check("ba_walk_rd", 32'(bus.ba), cyc - 1);
                    if (cur_we && cyc <= 3 * WW)  check("ba_walk_wr", 32'(bus.ba), (cyc - 1) / 3);
                end
                if (done_any) begin
                    if (in_access == 0) begin
                        check("spurious_done", 1, 0);
                    end else begin
                        check("done_port", 32'(bus.dma_done), owner);
                        check("latency", cyc, cur_we ? 3 * WW + 1 : WW + 1);
                        check("write_pulses", wr_falls - falls0, cur_we ? WW : 0);
                        if (cur_we) begin
                            check("mem_word", 32'(mem[cur_addr]), 32'(cur_wdata));
                            exp_mem[cur_addr] = cur_wdata;
                        end else begin
                            exp_rdata = exp_mem[cur_addr];
                        end
                        in_access = 0;
                    end
                end
                check("rdata_hold", 32'(bus.rdata), 32'(exp_rdata));
            end
            prev_write = bus.write;
            prev_ma    = bus.ma;
            prev_ba    = bus.ba;
            prev_mb    = bus.mb;
            prev_busy  = bus.busy;
            prev_done  = done_any;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (1) begin
            @(negedge sysclk); #2;
            if (cpu_q.size() == 0 && dma_q.size() == 0 && !active[0] && !active[1] && !bus.busy) break;
            n++;
            if (n > budget) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk); reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
    endtask

    function automatic req_t mk(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                                input int gap, input logic drop);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.gap = gap; r.drop = drop;
        return r;
    endfunction

    int            exp4 [6] = '{1, 1, 0, 1, 1, 1};
    logic [AW-1:0] a5;
    logic [WW-1:0] d5, old5;
    int            n5;
    bit            hit5;

    initial begin : main
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = WW'($urandom);
            exp_mem[i] = mem[i];
        end
        mem[7'o100] = 12'o7300;  exp_mem[7'o100] = 12'o7300;
        mem[7'o107] = 12'o2525;  exp_mem[7'o107] = 12'o2525;

        // Reset state.
        repeat (2) @(posedge sysclk);
        #1;
        check("reset_outputs", 32'({bus.ma, bus.ba, bus.mb, bus.write, bus.cpu_gnt, bus.dma_gnt,
                                     bus.cpu_done, bus.dma_done, bus.busy}), 0);
        check("reset_rdata", 32'(bus.rdata), 0);
        @(negedge sysclk); reset = 1'b0;

        // CPU read of a preloaded word.
        cpu_q.push_back(mk(1'b0, 7'o100, '0, 0, 1'b0));
        wait_idle(200);
        check("t1_rdata", 32'(bus.rdata), 32'(12'o7300));

        // CPU write, then DMA read-back of the same word.
        cpu_q.push_back(mk(1'b1, 7'o107, 12'o5252, 0, 1'b0));
        wait_idle(200);
        check("t2_mem", 32'(mem[7'o107]), 32'(12'o5252));
        dma_q.push_back(mk(1'b0, 7'o107, '0, 0, 1'b0));
        wait_idle(200);
        check("t2_rdata", 32'(bus.rdata), 32'(12'o5252));

        // Continuous ties from reset alternate, CPU first.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            cpu_q.push_back(mk(1'b0, AW'($urandom), '0, 0, 1'b0));
            dma_q.push_back(mk(1'b0, AW'($urandom), '0, 0, 1'b0));
        end
        wait_idle(500);
        check("t3_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("t3_order%0d", i), grant_log[i], i % 2);

        // DMA back-to-back, with a CPU request arriving mid-access.
        grant_log.delete();
        for (int i = 0; i < 5; i++) dma_q.push_back(mk(1'b0, AW'($urandom), '0, 0, 1'b0));
        cpu_q.push_back(mk(1'b0, AW'($urandom), '0, 20, 1'b0));
        wait_idle(500);
        check("t4_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("t4_order%0d", i), grant_log[i], exp4[i]);

        // Reset during bit 5 of a write (strobe not yet pulsed for bit 5).
        a5   = 7'o55;
        d5   = WW'($urandom);
        old5 = ~d5;
        mem[a5] = old5; exp_mem[a5] = old5;
        cpu_q.push_back(mk(1'b1, a5, d5, 0, 1'b0));
        hit5 = 0;
        n5   = 0;
        while (!hit5 && n5 < 100) begin
            @(negedge sysclk);
            if (bus.cpu_gnt && bus.ba == 4'd5 && !bus.write) hit5 = 1;
            n5++;
        end
        check("t5_reached_bit5", 32'(hit5), 1);
        reset = 1'b1;
        @(posedge sysclk); #1;
        check("t5_abort", 32'({bus.write, bus.cpu_gnt, bus.dma_gnt, bus.busy, bus.cpu_done, bus.dma_done}), 0);
        @(negedge sysclk); reset = 1'b0;
        exp_mem[a5] = (d5 & 12'h01F) | (old5 & ~12'h01F);
        check("t5_partial_word", 32'(mem[a5]), 32'(exp_mem[a5]));
        wait_idle(100);
        check("t5_busy", 32'(bus.busy), 0);

        // Randomized traffic on both ports, clustered addresses, some early req drops.
        for (int i = 0; i < 40; i++) begin
            cpu_q.push_back(mk(1'($urandom), AW'($urandom_range(0, 7)), WW'($urandom),
                               $urandom_range(0, 5), ($urandom_range(0, 3) == 0)));
            dma_q.push_back(mk(1'($urandom), AW'($urandom_range(0, 7)), WW'($urandom),
                               $urandom_range(0, 5), ($urandom_range(0, 3) == 0)));
        end
        wait_idle(20000);
        for (int i = 0; i < 8; i++) check($sformatf("final_mem%0d", i), 32'(mem[i]), 32'(exp_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
